// File: rtl/trig_sync_bank_pkg.sv
// Shared types and helpers for the trigger synchroniser bank.
// Holds the per-channel edge mode encoding and the edge qualification rule.
package trig_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } trig_mode_t;

    // True when a filtered-level transition old_lvl -> new_lvl should raise a pulse.
    function automatic logic edge_hit(input trig_mode_t mode, input logic old_lvl,
                                      input logic new_lvl);
        logic rise;
        logic fall;
        rise = ~old_lvl & new_lvl;
        fall = old_lvl & ~new_lvl;
        unique case (mode)
            MODE_RISE: return rise;
            MODE_FALL: return fall;
            MODE_BOTH: return rise | fall;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/trig_sync_bank_if.sv
// Per-channel signal bundle between the bank top and one trig_chan instance.
// All inputs are synchronous to CLK except idata, which is raw asynchronous.
interface trig_chan_if;
    import trig_pkg::*;

    logic       idata;
    logic       en;
    logic       clr;
    trig_mode_t mode;
    logic       odata;
    logic       opulse;
    logic       oflag;

    modport master (
        output idata, en, clr, mode,
        input  odata, opulse, oflag
    );

    modport slave (
        input  idata, en, clr, mode,
        output odata, opulse, oflag
    );

endinterface

// File: rtl/trig_sync_bank_chan.sv
// One trigger channel: synchroniser chain, stability filter, edge detector
// and sticky event flag, all clocked on clk_i with synchronous reset.
module trig_chan
    import trig_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    trig_chan_if.slave  bus
);

    localparam int CNT_W = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("trig_chan: SYNC_STAGES must be at least 2");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("trig_chan: FILT_LEN must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   odata_q, odata_d;
    logic                   opulse_q, opulse_d;
    logic                   oflag_q, oflag_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], bus.idata};
        cnt_d    = '0;
        odata_d  = odata_q;
        opulse_d = 1'b0;
        // A pulse seen last cycle wins over a clear in the same cycle.
        oflag_d  = opulse_q ? 1'b1 : (bus.clr ? 1'b0 : oflag_q);

        if (bus.en && (sync_lvl != odata_q)) begin
            if (cnt_q == CNT_LAST) begin
                odata_d  = sync_lvl;
                opulse_d = edge_hit(bus.mode, odata_q, sync_lvl);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            odata_q  <= 1'b0;
            opulse_q <= 1'b0;
            oflag_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            odata_q  <= odata_d;
            opulse_q <= opulse_d;
            oflag_q  <= oflag_d;
        end
    end

    assign bus.odata  = odata_q;
    assign bus.opulse = opulse_q;
    assign bus.oflag  = oflag_q;

endmodule

// File: rtl/trig_sync_bank.sv
// Bank of N independent trigger channels captured on CLK.
// The top only slices the per-channel mode field and ORs the sticky flags.
module trig_sync_bank
    import trig_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [N-1:0]   IDATA,
    input  logic [N-1:0]   EN,
    input  logic [2*N-1:0] MODE,
    input  logic [N-1:0]   CLR,
    output logic [N-1:0]   ODATA,
    output logic [N-1:0]   OPULSE,
    output logic [N-1:0]   OFLAG,
    output logic           OANY
);

    for (genvar i = 0; i < N; i++) begin : g_chan
        trig_chan_if ch_if ();

        assign ch_if.idata = IDATA[i];
        assign ch_if.en    = EN[i];
        assign ch_if.clr   = CLR[i];
        assign ch_if.mode  = trig_mode_t'(MODE[2*i+1 -: 2]);

        trig_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_chan (
            .clk_i (CLK),
            .rst_i (RST),
            .bus   (ch_if.slave)
        );

        assign ODATA[i]  = ch_if.odata;
        assign OPULSE[i] = ch_if.opulse;
        assign OFLAG[i]  = ch_if.oflag;
    end

    assign OANY = |OFLAG;

endmodule

// File: doc/trig_sync_bank.md
Name: trig_sync_bank

Overview:
- Parametrised successor to the per-bit flop bank: N asynchronous input bits captured on one clock instead of per-bit clocks.
- Per channel: multi-stage synchroniser, glitch filter, edge detector with per-channel mode, sticky event flag with clear.
- Sits at the boundary where unsynchronised trigger/status lines enter the CLK domain; feeds control logic and the interrupt aggregation.

Parameters:
- N, 4, number of channels.
- SYNC_STAGES, 2, synchroniser flop count per channel; must be ≥2 (elaboration error otherwise).
- FILT_LEN, 4, consecutive stable cycles required before the filtered level changes; must be ≥1.
- CNT_W, $clog2(FILT_LEN+1), filter counter width; derived, not overridden.

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- IDATA  in  N  asynchronous trigger inputs.
- EN  in  N  per-channel enable, synchronous to CLK.
- MODE  in  2*N  per-channel edge mode; bits [2i+1:2i] belong to channel i.
- CLR  in  N  per-channel sticky-flag clear, synchronous, level-sensitive.
- ODATA  out  N  filtered, synchronised level.
- OPULSE  out  N  one-cycle event pulse.
- OFLAG  out  N  sticky event flag.
- OANY  out  1  OR of all OFLAG bits (combinational from flag registers).

Behaviour:
- Reset (RST=1 at an edge): sync chains, filter counters, ODATA, OPULSE and OFLAG all cleared to 0. OANY=0. Applies mid-operation too: partial filter counts and pending events are discarded.
- Synchroniser: IDATA[i] shifts through SYNC_STAGES flops every cycle regardless of EN. The last stage is sync[i].
- Filter, per channel, each edge with EN[i]=1:
  - sync==ODATA → cnt<=0.
  - sync!=ODATA and cnt==FILT_LEN-1 → ODATA<=sync, cnt<=0.
  - Otherwise → cnt<=cnt+1.
- Latency: take the first sampling edge of an IDATA change as edge 1. ODATA changes at edge SYNC_STAGES+FILT_LEN; 6 with defaults. Pulses shorter than FILT_LEN cycles after synchronisation never reach ODATA.
- EN[i]=0: cnt held at 0, ODATA[i] held, OPULSE[i]=0, OFLAG[i] holds (CLR still effective). When EN rises with a sync/ODATA mismatch, ODATA updates FILT_LEN edges later.
- Edge detect: OPULSE[i] is registered and asserted in the same cycle ODATA[i] shows its new value, for exactly one cycle.
  - MODE 00 NONE: no pulse.
  - MODE 01 RISE: pulse on 0→1 only.
  - MODE 10 FALL: pulse on 1→0 only.
  - MODE 11 BOTH: pulse on either transition.
  - MODE is sampled at the update edge; changing MODE never creates a pulse by itself.
- Sticky flag: OFLAG[i] is set at the edge after OPULSE[i] is high. CLR[i] clears it at the next edge. If set and clear coincide, set wins so no event is lost.
- Channels are fully independent; simultaneous events on several channels are all reported.

Decomposition:
- Package trig_pkg:
  - enum trig_mode_t {MODE_NONE=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11}.
  - Function edge_hit(mode, old, new).
- Sub-module trig_chan: one channel (sync chain, filter, edge detect, flag), instantiated N times in a generate loop. The top level only slices MODE and computes OANY.

Test Plan:
- Power-up: RST=1 for 3 cycles with IDATA=4'hF, MODE all RISE, EN=4'hF. After release → ODATA=0 through edge 5, ODATA=4'hF at edge 6, OPULSE=4'hF for one cycle, then OFLAG=4'hF and OANY=1.
- Glitch rejection: IDATA[0] high for 3 cycles → ODATA[0], OPULSE[0] and OFLAG[0] stay 0. High for 4 cycles → ODATA[0] rises 6 edges after the first sample, then falls 4 cycles later.
- Modes: ch1 FALL, ch2 BOTH, ch3 NONE; IDATA[3:1] rise then fall, each held 10 cycles → OPULSE[1] only on the fall, OPULSE[2] on both, OPULSE[3] never. ODATA follows on all three.
- Flag clear: CLR=4'h1 with OFLAG=4'h1 → OFLAG=0 and OANY=0 next cycle. CLR[0] asserted in the same cycle as OPULSE[0] → OFLAG[0] is 1 afterwards.
- Enable gating: EN[2]=0, IDATA[2] toggled 0→1 and held → ODATA[2] stays 0 with no pulse. EN[2]=1 → ODATA[2]=1 after 4 edges, with a pulse if the mode allows.
- Mid-operation reset: RST pulsed while the ch0 counter is at 2 with IDATA[0]=1 held → all outputs 0 the next cycle. After release, ODATA[0]=1 at edge 6 with a rising pulse.
